// File: rtl/vec_wb_sequencer.sv
// Writeback sequencer: drains one multi-lane result vector into the per-lane register files,
// one lane per cycle, over a shared address/data bus. Option: VEC_WB_R0_PROTECT_EN.
module vec_wb_sequencer #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_valid,
  output logic                      wb_ready,
  input  logic [ADDR_W-1:0]         wb_rd,
  input  logic [LANES-1:0]          wb_mask,
  input  logic [LANES*DATA_W-1:0]   wb_data,
  input  logic                      flush,
  output logic [LANES-1:0]          regWriteW,
  output logic [ADDR_W-1:0]         RdestW,
  output logic [DATA_W-1:0]         resultWB,
  output logic                      stopWB,
  output logic                      busy
);

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  state_e                    state_q;
  logic [LANES*DATA_W-1:0]   data_q;
  // Lanes still to be written after the one currently on the bus.
  logic [LANES-1:0]          pend_q;

  logic                      last_lane;
  logic                      accept;
  logic [LANES-1:0]          eff_mask;
  logic [LANES-1:0]          src_mask;
  logic [LANES*DATA_W-1:0]   src_data;
  logic [LANES-1:0]          pick;
  logic [DATA_W-1:0]         pick_data;

  assign last_lane = (pend_q == '0);
  assign wb_ready  = ~rst & ~flush & ((state_q == StIdle) | last_lane);
  assign accept    = wb_valid & wb_ready;
  assign stopWB    = busy & ~wb_ready;

  always_comb begin
    eff_mask = wb_mask;
`ifdef VEC_WB_R0_PROTECT_EN
    // Register 0 is hard-wired zero: a vector aimed at it is consumed without writes.
    if (wb_rd == '0) eff_mask = '0;
`endif
  end

  // Next lane comes from the incoming vector on accept, else from the remaining pending lanes.
  always_comb begin
    src_mask  = accept ? eff_mask : pend_q;
    src_data  = accept ? wb_data : data_q;
    pick      = src_mask & (~src_mask + LANES'(1));
    pick_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (pick[i]) pick_data = pick_data | src_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      data_q    <= '0;
      pend_q    <= '0;
      regWriteW <= '0;
      RdestW    <= '0;
      resultWB  <= '0;
      busy      <= 1'b0;
    end else if (flush) begin
      state_q   <= StIdle;
      pend_q    <= '0;
      regWriteW <= '0;
      busy      <= 1'b0;
    end else if (state_q == StDrain && !last_lane) begin
      regWriteW <= pick;
      resultWB  <= pick_data;
      pend_q    <= pend_q & ~pick;
    end else if (accept && eff_mask != '0) begin
      state_q   <= StDrain;
      data_q    <= wb_data;
      pend_q    <= eff_mask & ~pick;
      regWriteW <= pick;
      RdestW    <= wb_rd;
      resultWB  <= pick_data;
      busy      <= 1'b1;
    end else begin
      // Drain finished (or zero-mask vector consumed): bus goes quiet.
      if (accept) data_q <= wb_data;
      state_q   <= StIdle;
      pend_q    <= '0;
      regWriteW <= '0;
      busy      <= 1'b0;
    end
  end

endmodule

// File: doc/vec_wb_sequencer.md
Name: vec_wb_sequencer

Overview:
- Schedules writeback into the four per-lane register files of the vector decode stage.
- The lanes share one 16-bit write-data bus and one destination-address bus. Each lane has its own write enable.
- Accepts one 4-lane result vector from the writeback stage and drains its enabled lanes into the register files, one lane per cycle.
- Asserts a pipeline stall while a drain is in progress.

Parameters:
- LANES, 4, number of vector lanes / register files
- DATA_W, 16, width of one lane result
- ADDR_W, 4, register address width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- wb_valid  in  1  result vector offered this cycle
- wb_ready  out  1  sequencer accepts the vector this cycle
- wb_rd  in  ADDR_W  destination register, common to all lanes
- wb_mask  in  LANES  per-lane write request; bit i = lane i
- wb_data  in  LANES*DATA_W  lane results; lane i occupies bits [i*DATA_W +: DATA_W]
- flush  in  1  synchronous abort of pending lane writes
- regWriteW  out  LANES  one-hot per-lane register-file write enable
- RdestW  out  ADDR_W  shared write address to all register files
- resultWB  out  DATA_W  shared write data to all register files
- stopWB  out  1  stall request to upstream pipeline registers
- busy  out  1  drain in progress

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; regWriteW=0, RdestW=0, resultWB=0, stopWB=0, busy=0; holding registers cleared. wb_ready=0 while rst is high.
- States:
  - IDLE: wb_ready=1.
  - DRAIN: wb_ready=1 only in the cycle that writes the last pending lane; otherwise 0.
- Accept rule: a transfer occurs on a rising clk edge with wb_valid & wb_ready. On accept, capture wb_rd, wb_mask and wb_data into holding registers.
- Zero-mask accept: if the effective mask is 0, the vector is consumed, no write occurs and the state is unchanged.
- Lane pointer: otherwise state=DRAIN and ptr = lowest set bit of the effective mask.
- Outputs are registered. The first write is visible in the cycle after the accept edge.
- Each DRAIN cycle:
  - regWriteW = onehot(ptr); RdestW = captured rd; resultWB = captured data[ptr].
  - Clear the pending bit for ptr; ptr advances to the next set bit in ascending lane order; masked-off lanes take 0 cycles.
- End of drain: after the last pending lane, return to IDLE, unless a new vector is accepted on that same edge. In that case reload the holding registers and stay in DRAIN with no bubble.
- Throughput: popcount(mask) cycles per vector when back-to-back. Latency from accept to first write is 1 cycle.
- Outputs: busy=1 in DRAIN. stopWB = busy & ~wb_ready. regWriteW is all-zero in every non-write cycle.
- flush (priority over accept): clears pending bits, state=IDLE, regWriteW=0 from the next cycle; wb_ready is forced 0 that cycle. A write already visible in the flush cycle completes; no later lane writes.
- Reset mid-drain: outputs go to reset values immediately (asynchronously); remaining lanes are discarded.
- wb_data and wb_mask are ignored when no transfer occurs. Changing them while wb_ready=0 has no effect.

Optional Feature:
- Macro: VEC_WB_R0_PROTECT_EN.
- Defined: when wb_rd==0, the effective mask is forced to 0. The vector is consumed with no writes, so register 0 stays constant zero in every lane.
- Undefined: register 0 is writable like any other register.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> all outputs 0 asynchronously; after release wb_ready=1, busy=0.
- Full vector: rd=5, mask=4'b1111, data={0x4444,0x3333,0x2222,0x1111} -> 4 consecutive cycles regWriteW=0001/0010/0100/1000, RdestW=5, resultWB=0x1111,0x2222,0x3333,0x4444; stopWB=1 for the first 3 of those cycles.
- Sparse mask: rd=2, mask=4'b1010, data lane1=0xAAAA, lane3=0xBBBB -> 2 write cycles: 0010/0xAAAA then 1000/0xBBBB; no cycle for lanes 0 and 2.
- Back-to-back: second vector rd=7, mask=0001, data=0x00FF, held valid during the first drain -> accepted on the last-lane cycle; next cycle regWriteW=0001, RdestW=7, resultWB=0x00FF, no bubble.
- Flush: flush asserted on the second cycle of a mask=1111 drain -> exactly lanes 0 and 1 written, then IDLE and busy=0.
- Zero-mask and R0: mask=0 -> consumed, no write; with VEC_WB_R0_PROTECT_EN, rd=0, mask=1111 -> consumed, zero writes; without the macro -> 4 writes to r0.
